seq_detector: RTL and testbench
===============================

SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter MAX_W, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 16: match counter width.
REQ-003 SHALL have parameters DEF_PATTERN (default 8'b0000_0101), DEF_LEN (default 3) and DEF_OVERLAP (default 1): the configuration loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the in bit is accepted on a clk edge where in_valid=1.
REQ-007 SHALL have port in, input, 1 bit: serial data bit.
REQ-008 SHALL have port cfg_load, input, 1 bit: loads the cfg_* values on a clk edge.
REQ-009 SHALL have port cfg_pattern, input, MAX_W bits: pattern, LSB = most recent bit.
REQ-010 SHALL have port cfg_len, input, $clog2(MAX_W+1) bits: pattern length.
REQ-011 SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping matches, 0 = non-overlapping.
REQ-012 SHALL have port out, output, 1 bit: one-cycle match pulse.
REQ-013 SHALL have port match_count, output, CNT_W bits: saturating count of matches.

Function
REQ-014 SHALL keep a history register hist (MAX_W bits); on an accepted bit, hist <= {hist[MAX_W-2:0], in}.
REQ-015 SHALL keep a fill counter; on an accepted bit, fill <= min(fill+1, len).
REQ-016 SHALL detect a match on an accepted bit when the post-shift fill equals len and the post-shift hist[len-1:0] equals pattern[len-1:0].
REQ-017 SHALL register out, asserting it for exactly one cycle, starting at the same edge that accepts the completing bit (latency 1 edge).
REQ-018 SHALL hold out at 0 in every cycle with no match, including every cycle where in_valid=0.
REQ-019 SHALL, in overlap mode, leave fill unchanged on a match, so a suffix can start the next match ("10101" with pattern 101 gives 2 matches).
REQ-020 SHALL, in non-overlap mode, clear fill to 0 on a match ("10101" with pattern 101 gives 1 match).
REQ-021 SHALL clamp the stored len: cfg_len=0 or 1 is stored as 1; cfg_len>MAX_W is stored as MAX_W.
REQ-022 SHALL, on cfg_load, store pattern, the clamped len and overlap, and clear hist, fill, out and match_count.
REQ-023 SHALL give cfg_load priority over in_valid on the same edge; the input bit is dropped.
REQ-024 SHALL increment match_count by 1 on each match.
REQ-025 SHALL saturate match_count at 2^CNT_W-1 and never wrap.
REQ-026 SHALL ignore in whenever in_valid=0: no state changes.

Reset
REQ-027 SHALL, on reset assertion and independent of clk, drive out=0 and match_count=0, clear hist and fill, and load pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
REQ-028 SHALL, on reset asserted mid-sequence, discard the partial match; the first post-reset match needs a full len accepted bits.
REQ-029 SHALL, on the first edge after reset deasserts, respond to in_valid and cfg_load normally.

Structure
REQ-030 SHALL place the default constants and the length clamp function in package seq_det_pkg.
REQ-031 SHALL implement the saturating counter as sub-module sat_counter (parameter W; ports clk, reset, clr, inc, count).
REQ-032 SHALL use a single two-state control FSM: FILLING (fill<len) and ARMED (fill==len). An accepted bit in FILLING moves to ARMED when fill+1==len. A non-overlap match moves ARMED back to FILLING. cfg_load and reset move to FILLING.

Verification
REQ-033 SHALL cover: defaults, in stream 1,0,1,0,1 all valid -> out high after the 3rd and 5th bits; match_count=2.
REQ-034 SHALL cover: cfg_load with pattern 0110, len 4, overlap 0, then stream 0110110 -> one match after the 4th bit; the 7th bit gives no match; match_count=1.
REQ-035 SHALL cover: defaults, bits 1,0,1 with in_valid=0 cycles inserted between them -> exactly one pulse, one cycle after the 3rd valid edge.
REQ-036 SHALL cover: reset pulsed after bits 1,0 -> the following bit 1 gives no match; match_count=0.
REQ-037 SHALL cover: CNT_W=2 with 5 matches -> match_count stays at 3.
REQ-038 SHALL cover: cfg_load with in_valid=1 on the same edge, cfg_len=0 -> the bit is dropped, len=1, and the next bit equal to pattern[0] matches.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: reset defaults, control states and the pattern-length clamp for seq_detector.
package seq_det_pkg;

    localparam logic [7:0] DEF_PATTERN_C = 8'b0000_0101;
    localparam int         DEF_LEN_C     = 3;
    localparam logic       DEF_OVERLAP_C = 1'b1;

    typedef enum logic {FILLING, ARMED} state_e;

    // Lengths 0 and 1 both mean a single-bit pattern; anything longer than the history is capped.
    function automatic int clamp_len(input int len, input int max_w);
        return (len < 1) ? 1 : (len > max_w) ? max_w : len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
    parameter int W = 16
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = clr ? '0 : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector.sv
// seq_detector: serial pattern matcher with runtime-loadable pattern/length/overlap and a saturating hit count.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int               MAX_W       = 8,
    parameter int               CNT_W       = 16,
    parameter logic [MAX_W-1:0] DEF_PATTERN = MAX_W'(DEF_PATTERN_C),
    parameter int               DEF_LEN     = DEF_LEN_C,
    parameter logic             DEF_OVERLAP = DEF_OVERLAP_C,
    localparam int              LW          = $clog2(MAX_W + 1)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_load,
    input  logic [MAX_W-1:0] cfg_pattern,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    logic [MAX_W-1:0] hist_q, hist_d, pat_q, pat_d, hist_sh, mask;
    logic [LW-1:0]    fill_q, fill_d, len_q, len_d, fill_inc;
    logic             ovl_q, ovl_d, out_q, out_d, match;
    state_e           state_q, state_d;

    always_comb begin
        hist_sh  = {hist_q[MAX_W-2:0], in};
        mask     = ~({MAX_W{1'b1}} << len_q);
        // ARMED means the window is already full, so the fill count saturates at len
        fill_inc = (state_q == ARMED) ? len_q : fill_q + 1'b1;
        match    = in_valid && !cfg_load && fill_inc == len_q && ((hist_sh ^ pat_q) & mask) == '0;
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        state_d  = state_q;
        out_d    = match;
        if (cfg_load) begin
            pat_d   = cfg_pattern;
            len_d   = LW'(clamp_len(int'(cfg_len), MAX_W));
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILLING;
        end else if (in_valid) begin
            hist_d  = hist_sh;
            fill_d  = (match && !ovl_q) ? '0 : fill_inc;
            state_d = (fill_d == len_q) ? ARMED : FILLING;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= DEF_PATTERN;
            len_q   <= LW'(clamp_len(DEF_LEN, MAX_W));
            ovl_q   <= DEF_OVERLAP;
            out_q   <= 1'b0;
            state_q <= FILLING;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            out_q   <= out_d;
            state_q <= state_d;
        end
    end

    assign out = out_q;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cfg_load),
        .inc   (match),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: directed vectors with hand-computed expectations for seq_detector.
module tb_seq_detector;

    logic        clk = 0, reset = 0, in_valid = 0, in = 0, cfg_load = 0, cfg_overlap = 0;
    logic [7:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic        out, out2;
    logic [15:0] match_count;
    logic [1:0]  mc2;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    seq_detector dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .out(out), .match_count(match_count)
    );

    seq_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .out(out2), .match_count(mc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b);
        in_valid = v;
        in       = b;
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic v, input logic b);
        cfg_load    = 1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_valid    = v;
        in          = b;
        @(posedge clk);
        #1;
        cfg_load = 0;
        in_valid = 0;
    endtask

    // Feeds n valid bits MSB first and checks out after each edge against exp (MSB first).
    task automatic feed(input string tag, input logic [31:0] bits, input int n, input logic [31:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i]);
            chk(tag, 32'(out), 32'(exp[i]));
        end
    endtask

    initial begin
        #1 reset = 1;
        #1;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_count", 32'(match_count), 32'd0);
        @(posedge clk);
        #1 reset = 0;

        feed("t1_out", 32'b10101, 5, 32'b00101);
        chk("t1_count", 32'(match_count), 32'd2);
        step(1'b0, 1'b1);
        chk("t1_idle_out", 32'(out), 32'd0);

        load(8'b0110, 4'd4, 1'b0, 1'b0, 1'b0);
        chk("t2_load_out", 32'(out), 32'd0);
        chk("t2_load_count", 32'(match_count), 32'd0);
        feed("t2_out", 32'b0110110, 7, 32'b0001000);
        chk("t2_count", 32'(match_count), 32'd1);

        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1); chk("t3_v1", 32'(out), 32'd0);
        step(1'b0, 1'b0); chk("t3_i1", 32'(out), 32'd0);
        step(1'b0, 1'b1); chk("t3_i2", 32'(out), 32'd0);
        step(1'b1, 1'b0); chk("t3_v2", 32'(out), 32'd0);
        step(1'b0, 1'b1); chk("t3_i3", 32'(out), 32'd0);
        step(1'b1, 1'b1); chk("t3_v3", 32'(out), 32'd1);
        step(1'b0, 1'b1); chk("t3_i4", 32'(out), 32'd0);
        chk("t3_count", 32'(match_count), 32'd1);

        feed("t4_pre", 32'b10, 2, 32'b00);
        #1 reset = 1;
        #1;
        chk("t4_async_out", 32'(out), 32'd0);
        chk("t4_async_count", 32'(match_count), 32'd0);
        #1 reset = 0;
        step(1'b1, 1'b1);
        chk("t4_first_out", 32'(out), 32'd0);
        chk("t4_first_count", 32'(match_count), 32'd0);
        feed("t4_post", 32'b01, 2, 32'b01);
        chk("t4_count", 32'(match_count), 32'd1);

        load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
        feed("t5_out", 32'b10101010101, 11, 32'b00101010101);
        chk("t5_count", 32'(match_count), 32'd5);
        chk("t5_sat_count", 32'(mc2), 32'd3);

        load(8'b10, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("t6_load_out", 32'(out), 32'd0);
        chk("t6_load_count", 32'(match_count), 32'd0);
        feed("t6_out", 32'b100, 3, 32'b011);
        chk("t6_count", 32'(match_count), 32'd2);

        load(8'hA5, 4'd15, 1'b0, 1'b0, 1'b0);
        feed("t7_out", 32'hA5, 8, 32'h01);
        feed("t7_nov", 32'h5, 4, 32'h0);
        chk("t7_count", 32'(match_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
